// File: rtl/sbus_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : sbus_encoder_if
// Purpose  : Bundles the request/status/serial signals of the S.BUS frame
//            encoder so that the producer side and the encoder side can be
//            connected with a single port.
// Signals  : ch_data     [175:0]  16 x 11-bit channels, ch n at [11n+10:11n]
//            flags       [3:0]    {failsafe, frame_lost, ch18, ch17}
//            frame_start          single-frame request
//            auto_en              periodic frame generator enable
//            busy                 frame in progress
//            frame_done           one-cycle end-of-frame pulse
//            sbus_txd             registered serial line
// Modports : master - frame producer / line observer
//            slave  - the encoder itself
// Revision : 1.0 - initial release
// ============================================================================
interface sbus_encoder_if;
  logic [175:0] ch_data;
  logic [3:0]   flags;
  logic         frame_start;
  logic         auto_en;
  logic         busy;
  logic         frame_done;
  logic         sbus_txd;

  modport master (
    output ch_data, flags, frame_start, auto_en,
    input  busy, frame_done, sbus_txd
  );

  modport slave (
    input  ch_data, flags, frame_start, auto_en,
    output busy, frame_done, sbus_txd
  );
endinterface
`default_nettype wire

// File: rtl/sbus_encoder.sv
`default_nettype none
// ============================================================================
// Module   : sbus_encoder
// Purpose  : Builds the 25-byte S.BUS frame (0x0F, 22 channel bytes, flag
//            byte, 0x00) from a snapshot of 16 x 11-bit channels and 4 flags
//            and shifts it out as 8E2 UART at BIT_RATE, optionally inverted.
//            Frames start on request or from a free-running period timer.
// Ports    : clk    - system clock, rising edge
//            reset  - asynchronous, active-high
//            bus    - sbus_encoder_if.slave (ch_data, flags, frame_start,
//                     auto_en in; busy, frame_done, sbus_txd out)
// Revision : 1.0 - initial release
// ============================================================================
module sbus_encoder #(
  parameter int CLK_HZ            = 50000000,
  parameter int BIT_RATE          = 100000,
  parameter int FRAME_PERIOD_CLKS = 700000,
  parameter int INVERT            = 1
) (
  input wire            clk,
  input wire            reset,
  sbus_encoder_if.slave bus
);

  localparam int c_CPB = CLK_HZ / BIT_RATE;
  localparam int c_BCW = $clog2(c_CPB);
  localparam int c_PCW = (FRAME_PERIOD_CLKS > 1) ? $clog2(FRAME_PERIOD_CLKS) : 1;

  localparam logic [c_BCW-1:0] c_BIT_LAST    = c_BCW'(c_CPB - 1);
  localparam logic [c_BCW-1:0] c_BIT_ONE     = c_BCW'(1);
  localparam logic [c_PCW-1:0] c_PERIOD_LAST = c_PCW'(FRAME_PERIOD_CLKS - 1);
  localparam logic [c_PCW-1:0] c_PERIOD_ONE  = c_PCW'(1);
  localparam logic             c_INV         = (INVERT != 0);
  localparam logic [4:0]       c_LAST_BYTE   = 5'd24;
  localparam logic [7:0]       c_SYNC_BYTE   = 8'h0F;

  // The one-cycle "done" step after the last stop bit is the IDLE cycle in
  // which frame_done is high, so no separate DONE encoding is needed.
  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  logic [2:0]       r_state;
  logic [c_BCW-1:0] r_bit_cnt;    // clock cycles within the current bit
  logic [2:0]       r_bit_idx;    // data bit 0..7, reused as stop bit 0..1
  logic [4:0]       r_byte_idx;   // frame byte 0..24
  logic [c_PCW-1:0] r_period_cnt;
  logic             r_pending;
  logic [179:0]     r_snap;       // {flags, ch_data} captured at acceptance
  logic             r_busy;
  logic             r_frame_done;
  logic             r_txd;

  logic [2:0]       w_state_nxt;
  logic [c_BCW-1:0] w_bit_cnt_nxt;
  logic [2:0]       w_bit_idx_nxt;
  logic [4:0]       w_byte_idx_nxt;
  logic [c_PCW-1:0] w_period_cnt_nxt;
  logic             w_pending_nxt;
  logic             w_done_nxt;
  logic             w_line_nxt;
  logic             w_bit_end;
  logic             w_fire;
  logic             w_accept;
  logic [199:0]     w_frame;

  // Whole frame as a flat byte array: byte k lives at [8k+7:8k], so the
  // concatenation {byte_idx, bit_idx} addresses a single frame bit directly.
  assign w_frame   = {8'h00, 4'h0, r_snap, c_SYNC_BYTE};
  assign w_bit_end = (r_bit_cnt == c_BIT_LAST);
  assign w_fire    = bus.auto_en && (r_period_cnt == c_PERIOD_LAST);
  assign w_accept  = (r_state == c_IDLE) &&
                     (bus.frame_start || w_fire || (r_pending && bus.auto_en));

  // State and counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_byte_idx   <= '0;
      r_period_cnt <= '0;
      r_pending    <= 1'b0;
      r_snap       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_txd        <= ~c_INV;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_period_cnt <= w_period_cnt_nxt;
      r_pending    <= w_pending_nxt;
      r_busy       <= (w_state_nxt != c_IDLE);
      r_frame_done <= w_done_nxt;
      r_txd        <= w_line_nxt ^ c_INV;
      if (w_accept) begin
        r_snap <= {bus.flags, bus.ch_data};
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_done_nxt     = 1'b0;

    if (r_state != c_IDLE) begin
      w_bit_cnt_nxt = w_bit_end ? '0 : r_bit_cnt + c_BIT_ONE;
    end

    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_state_nxt    = c_START;
          w_bit_cnt_nxt  = '0;
          w_bit_idx_nxt  = '0;
          w_byte_idx_nxt = '0;
        end
      end
      c_START: begin
        if (w_bit_end) begin
          w_state_nxt   = c_DATA;
          w_bit_idx_nxt = '0;
        end
      end
      c_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt   = c_PARITY;
            w_bit_idx_nxt = '0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      c_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt   = c_STOP;
          w_bit_idx_nxt = '0;
        end
      end
      c_STOP: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd1) begin
            w_bit_idx_nxt = '0;
            if (r_byte_idx == c_LAST_BYTE) begin
              w_state_nxt    = c_IDLE;
              w_byte_idx_nxt = '0;
              w_done_nxt     = 1'b1;
            end else begin
              w_state_nxt    = c_START;
              w_byte_idx_nxt = r_byte_idx + 5'd1;
            end
          end else begin
            w_bit_idx_nxt = 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // Period timer: a fire while a frame is running is remembered in
  // r_pending; dropping auto_en forgets both the count and the request.
  always_comb begin
    w_period_cnt_nxt = r_period_cnt + c_PERIOD_ONE;
    w_pending_nxt    = r_pending;
    if (!bus.auto_en) begin
      w_period_cnt_nxt = '0;
      w_pending_nxt    = 1'b0;
    end else if (w_accept) begin
      w_period_cnt_nxt = '0;
      w_pending_nxt    = 1'b0;
    end else if (w_fire) begin
      w_period_cnt_nxt = '0;
      w_pending_nxt    = 1'b1;
    end
  end

  // Output logic: uninverted line level for the state being entered, so the
  // registered txd changes on the same edge as the state.
  always_comb begin
    w_line_nxt = 1'b1;
    case (w_state_nxt)
      c_START:  w_line_nxt = 1'b0;
      c_DATA:   w_line_nxt = w_frame[{w_byte_idx_nxt, w_bit_idx_nxt}];
      c_PARITY: w_line_nxt = ^w_frame[{w_byte_idx_nxt, 3'b000} +: 8];
      default:  w_line_nxt = 1'b1;
    endcase
  end

  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.sbus_txd   = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_sbus_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbus_encoder
// Purpose  : Self-checking bench for sbus_encoder. Two encoders at 10 clocks
//            per bit: u_dut_a (inverted line, 5000-cycle period) and u_dut_b
//            (plain line, 1000-cycle period). Expected bytes come from a
//            bit-stream model of the channel packing; the line is decoded as
//            8E2 UART at mid-bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbus_encoder;

  localparam int CLK_HZ   = 1000000;
  localparam int BIT_RATE = 100000;
  localparam int CPB      = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sbus_encoder_if if_a ();
  sbus_encoder_if if_b ();

  sbus_encoder #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .FRAME_PERIOD_CLKS(5000), .INVERT(1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );

  sbus_encoder #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .FRAME_PERIOD_CLKS(1000), .INVERT(0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor mux: selects which encoder is decoded; mon_line is the
  // uninverted UART level.
  logic sel_b;
  logic mon_busy, mon_done, mon_line;
  always_comb begin
    mon_busy = sel_b ? if_b.busy       : if_a.busy;
    mon_done = sel_b ? if_b.frame_done : if_a.frame_done;
    mon_line = sel_b ? if_b.sbus_txd   : ~if_a.sbus_txd;
  end

  logic [10:0] m_ch [16];
  logic [3:0]  m_flags;
  logic [7:0]  exp_b [25];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: channels form one little-endian bit stream, 8 bits per byte.
  task automatic model_frame();
    bit q[$];
    q.delete();
    for (int n = 0; n < 16; n++)
      for (int b = 0; b < 11; b++)
        q.push_back(m_ch[n][b]);
    exp_b[0] = 8'h0F;
    for (int k = 1; k <= 22; k++)
      for (int b = 0; b < 8; b++)
        exp_b[k][b] = q[8*(k-1) + b];
    exp_b[23] = {4'b0000, m_flags};
    exp_b[24] = 8'h00;
  endtask

  task automatic randomize_model();
    for (int n = 0; n < 16; n++) m_ch[n] = 11'($urandom);
    m_flags = 4'($urandom);
  endtask

  task automatic drive(input logic to_b);
    logic [175:0] v;
    for (int n = 0; n < 16; n++) v[11*n +: 11] = m_ch[n];
    if (to_b) begin
      if_b.ch_data = v;
      if_b.flags   = m_flags;
    end else begin
      if_a.ch_data = v;
      if_a.flags   = m_flags;
    end
    model_frame();
  endtask

  task automatic pulse(input logic to_b);
    if (to_b) if_b.frame_start = 1'b1; else if_a.frame_start = 1'b1;
    tick();
    if (to_b) if_b.frame_start = 1'b0; else if_a.frame_start = 1'b0;
  endtask

  // Waits (bounded) for busy, then decodes 25 bytes at mid-bit and checks
  // busy across the frame and the frame_done pulse right after it.
  task automatic check_frame(input string tag, input int max_wait,
                             output int waited, output int start_cyc);
    int n;
    logic [11:0] bits;
    logic busy_ok;
    n = 0;
    while (mon_busy !== 1'b1 && n < max_wait) begin
      tick();
      n++;
    end
    waited    = n;
    start_cyc = cyc;
    check($sformatf("%s busy rise", tag), mon_busy, 1);
    busy_ok = 1'b1;
    for (int k = 0; k < 25; k++) begin
      for (int b = 0; b < 12; b++) begin
        repeat (CPB/2) tick();
        bits[b] = mon_line;
        busy_ok = busy_ok & (mon_busy === 1'b1);
        repeat (CPB/2 - 1) tick();
        busy_ok = busy_ok & (mon_busy === 1'b1);
        tick();
      end
      check($sformatf("%s B%0d data", tag, k), bits[8:1], exp_b[k]);
      check($sformatf("%s B%0d start/parity/stops", tag, k),
            {bits[0], bits[9], bits[11:10]}, {1'b0, ^exp_b[k], 2'b11});
    end
    check($sformatf("%s busy 3000 cycles", tag), busy_ok, 1);
    check($sformatf("%s busy low at end", tag), mon_busy, 0);
    check($sformatf("%s frame_done pulse", tag), mon_done, 1);
    tick();
    check($sformatf("%s frame_done one cycle", tag), mon_done, 0);
  endtask

  initial begin
    int w, s0, s1, s2, en_cyc, cnt;
    logic [175:0] junk;

    reset = 1'b1;
    sel_b = 1'b0;
    if_a.ch_data = '0; if_a.flags = '0; if_a.frame_start = 1'b0; if_a.auto_en = 1'b0;
    if_b.ch_data = '0; if_b.flags = '0; if_b.frame_start = 1'b0; if_b.auto_en = 1'b0;
    repeat (3) tick();
    check("reset busy_a", if_a.busy, 0);
    check("reset done_a", if_a.frame_done, 0);
    check("reset txd_a idle", if_a.sbus_txd, 0);
    check("reset busy_b", if_b.busy, 0);
    check("reset done_b", if_b.frame_done, 0);
    check("reset txd_b idle", if_b.sbus_txd, 1);
    reset = 1'b0;
    repeat (2) tick();

    // Mid-scale channels, inverted line
    for (int n = 0; n < 16; n++) m_ch[n] = 11'h400;
    m_flags = 4'b0000;
    drive(1'b0);
    pulse(1'b0);
    check_frame("s1", 5, w, s0);
    check("s1 start latency", w, 0);

    // Full-scale ch0 and failsafe/frame_lost flags
    for (int n = 0; n < 16; n++) m_ch[n] = 11'h000;
    m_ch[0] = 11'h7FF;
    m_flags = 4'b1100;
    drive(1'b0);
    pulse(1'b0);
    check_frame("s2", 5, w, s0);

    for (int r = 0; r < 2; r++) begin
      randomize_model();
      drive(1'b0);
      pulse(1'b0);
      check_frame($sformatf("rnd%0d", r), 5, w, s0);
    end

    // Retrigger and input change mid-frame
    randomize_model();
    drive(1'b0);
    pulse(1'b0);
    fork
      check_frame("s3", 5, w, s0);
      begin
        repeat (500) tick();
        for (int i = 0; i < 176; i++) junk[i] = 1'($urandom_range(0, 1));
        if_a.ch_data     = junk;
        if_a.flags       = ~m_flags;
        if_a.frame_start = 1'b1;
        tick();
        if_a.frame_start = 1'b0;
      end
    join
    cnt = 0;
    repeat (50) begin
      tick();
      if (mon_busy === 1'b1) cnt++;
    end
    check("s3 no queued frame", cnt, 0);

    // Asynchronous reset mid-frame
    randomize_model();
    drive(1'b0);
    pulse(1'b0);
    repeat (1234) tick();
    check("s5 busy before reset", mon_busy, 1);
    #1 reset = 1'b1;
    #1;
    check("s5 txd idle at once", if_a.sbus_txd, 0);
    check("s5 busy cleared", if_a.busy, 0);
    check("s5 no frame_done", if_a.frame_done, 0);
    tick();
    tick();
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      tick();
      if (mon_busy !== 1'b0 || mon_done !== 1'b0) cnt++;
    end
    check("s5 quiet after reset", cnt, 0);
    randomize_model();
    drive(1'b0);
    pulse(1'b0);
    check_frame("s5 next", 5, w, s0);

    // Periodic frames, 5000-cycle period
    randomize_model();
    drive(1'b0);
    if_a.auto_en = 1'b1;
    en_cyc = cyc;
    check_frame("s4a f1", 6000, w, s1);
    check("s4a first start", s1 - en_cyc, 5000);
    check_frame("s4a f2", 8000, w, s2);
    check("s4a second start", s2 - en_cyc, 10000);
    if_a.auto_en = 1'b0;

    // Plain polarity, same content as the first frame
    sel_b = 1'b1;
    check("s6 idle level", if_b.sbus_txd, 1);
    for (int n = 0; n < 16; n++) m_ch[n] = 11'h400;
    m_flags = 4'b0000;
    drive(1'b1);
    pulse(1'b1);
    check_frame("s6", 5, w, s0);
    check("s6 start latency", w, 0);

    // Period shorter than a frame: back-to-back, then auto_en dropped mid-frame
    randomize_model();
    drive(1'b1);
    if_b.auto_en = 1'b1;
    en_cyc = cyc;
    check_frame("s4b f1", 1500, w, s1);
    check("s4b first start", s1 - en_cyc, 1000);
    check_frame("s4b f2", 5, w, s2);
    check("s4b back-to-back f2", s2 - s1, 3001);
    fork
      check_frame("s4b f3", 5, w, s0);
      begin
        repeat (1500) tick();
        if_b.auto_en = 1'b0;
      end
    join
    check("s4b back-to-back f3", s0 - s2, 3001);
    cnt = 0;
    repeat (2500) begin
      tick();
      if (mon_busy === 1'b1) cnt++;
    end
    check("s4b pending dropped", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, expected end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sbus_encoder.md
Name: sbus_encoder

Overview:
- Generates S.BUS frames: the transmit counterpart of the S.BUS decoder path (uart_rx + frame assembler).
- Packs 16 x 11-bit channels plus 4 flag bits into the 25-byte S.BUS frame.
- Serialises the frame directly as 8E2 UART at BIT_RATE, with optional line inversion, for servo/receiver emulation and loopback testing of the decoder.
- Frames are sent on request or periodically.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BIT_RATE, 100000: serial bit rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer, >= 4).
- FRAME_PERIOD_CLKS, 700000: auto-mode frame start interval in clk cycles (14 ms at 50 MHz).
- INVERT, 1: 1 means the output line is inverted (standard S.BUS); 0 means plain UART polarity.

Ports:
- clk, input, 1: system clock, all logic on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- ch_data, input, 176: channel n (0..15) at ch_data[11n+10:11n].
- flags, input, 4: [0] ch17, [1] ch18, [2] frame_lost, [3] failsafe.
- frame_start, input, 1: single-frame request, sampled every cycle.
- auto_en, input, 1: enables the periodic frame generator.
- busy, output, 1: high while a frame is being transmitted.
- frame_done, output, 1: one-cycle pulse at the end of each completed frame.
- sbus_txd, output, 1: registered serial output.

Behaviour:
- Reset values:
  - busy = 0 and frame_done = 0.
  - sbus_txd = idle level: 0 if INVERT=1, 1 if INVERT=0.
  - All counters = 0; state = IDLE.
- Reset asserted mid-frame aborts the frame immediately. sbus_txd returns to idle asynchronously, and no frame_done pulse is issued.
- Frame bytes:
  - B0 = 0x0F.
  - Bk = ch_data[8(k-1)+7 : 8(k-1)] for k = 1..22.
  - B23 = {4'b0000, flags}.
  - B24 = 0x00.
- Byte format: start bit (0), 8 data bits LSB first, even parity bit (XOR of the data bits), 2 stop bits (1). That is 12 bits per byte, with no inter-byte gap.
  - Frame length = 300 bits = 300*CYCLES_PER_BIT cycles.
- Line level: internal line level L (idle = 1); sbus_txd = INVERT ? ~L : L.
- Snapshot: ch_data and flags are captured into an internal frame register in the acceptance cycle. Input changes during a frame do not affect that frame.
- Start trigger:
  - Accepted only in IDLE, when frame_start=1 or the auto timer fires.
  - Both in the same cycle produce one frame.
  - frame_start while busy=1 is ignored (not queued).
- Start timing: with acceptance at edge N, busy=1 and the start bit of B0 are on sbus_txd from edge N+1.
- States: IDLE -> START -> DATA (8 bits) -> PARITY -> STOP (2 bits) -> START of the next byte, or DONE after B24 -> IDLE.
  - Each bit is held exactly CYCLES_PER_BIT cycles.
  - Byte index counts 0..24; bit index counts 0..7.
- Frame end:
  - The second stop bit of B24 completes after 300*CYCLES_PER_BIT cycles of busy.
  - On the next edge busy=0, frame_done=1 for exactly one cycle, and state = IDLE.
  - A new frame may be accepted in that same cycle, giving back-to-back frames.
- Auto timer:
  - The period counter counts while auto_en=1. It is cleared when auto_en=0 and reloaded to 0 at every frame acceptance.
  - It fires when it reaches FRAME_PERIOD_CLKS-1. If busy at that point, the request is held pending and the frame starts in the first IDLE cycle.
  - If FRAME_PERIOD_CLKS is shorter than the frame, frames run back-to-back.
  - auto_en 0->1: the first frame starts FRAME_PERIOD_CLKS cycles later, not immediately.
  - Deasserting auto_en mid-frame finishes the current frame and drops any pending request.
- Counter widths: the bit-time counter is sized by $clog2(CYCLES_PER_BIT) and the period counter by $clog2(FRAME_PERIOD_CLKS). Neither may overflow.

Test Plan:
- Test parameters: CLK_HZ=1000000, BIT_RATE=100000 (10 cycles/bit).
- Every scenario checks parity, 2 stop bits and 3000-cycle busy.
- (1) All channels = 0x400, flags = 0, single frame_start pulse, INVERT=1 -> de-inverted bytes 0x0F, 0x00, 0x04, 0x20, ... and B23 = 0x00, B24 = 0x00; frame_done pulse at cycle 3001 after the start.
- (2) ch0 = 0x7FF, others 0, flags = 4'b1100 -> B1 = 0xFF, B2 = 0x07, B23 = 0x0C (parity 0), B24 = 0x00.
- (3) frame_start pulsed again at cycle 500 of a frame, and ch_data changed mid-frame -> exactly one frame, with data equal to the snapshot.
- (4) auto_en=1, FRAME_PERIOD_CLKS=5000 -> frame starts at 5000 and 10000 cycles after enable. With FRAME_PERIOD_CLKS=1000 -> back-to-back frames, each start in the cycle of the previous frame_done.
- (5) reset asserted at cycle 1234 of a frame -> sbus_txd idle immediately, busy=0, no frame_done; the next frame_start produces a complete, correct frame.
- (6) INVERT=0, repeat scenario (1) -> idle line = 1, start bit = 0, identical decoded bytes.
